// File: rtl/regfile_access_ctrl.sv
// Access sequencer for the single-port 8x8 register file: arbitrates decode reads
// against execute/load writebacks and splits 16-bit writes. Option: REGFILE_PAIR_CHECK_EN.
module regfile_access_ctrl #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [2:0]  rd_rs1_addr,
  input  logic [2:0]  rd_rs2_addr,
  output logic        rd_gnt,
  output logic        rd_vld,
  output logic [7:0]  rd_rs1_q,
  output logic [7:0]  rd_rs2_q,
  input  logic        wb_req,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  input  logic        wb_len,
  output logic        wb_gnt,
  input  logic        ld_req,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic        ld_len,
  output logic        ld_gnt,
  output logic [2:0]  rf_rs1_addr,
  output logic [2:0]  rf_rs2_addr,
  output logic [2:0]  rf_rd_addr,
  output logic [7:0]  rf_rd_data,
  output logic        rf_r_w,
  input  logic [7:0]  rf_rs1_data,
  input  logic [7:0]  rf_rs2_data,
  output logic        busy,
  output logic        err
);
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  typedef enum logic {IDLE, WR_LO} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            rr_ld_q, rr_ld_d;
  logic [AW-1:0]   lo_addr_q, lo_addr_d;
  logic [DW-1:0]   lo_data_q, lo_data_d;

  logic            rd_gnt_d, wb_gnt_d, ld_gnt_d, rd_vld_d, busy_d, err_d, rf_r_w_d;
  logic [DW-1:0]   rd_rs1_d, rd_rs2_d, rf_rd_data_d;
  logic [AW-1:0]   rf_rs1_addr_d, rf_rs2_addr_d, rf_rd_addr_d;

  logic            wr_pend, sel_ld, starved, pair_bad, w_len;
  logic [AW-1:0]   w_addr;
  logic [15:0]     w_data;

  // Write-side winner: round-robin only matters when both writers are pending.
  assign wr_pend = wb_req | ld_req;
  assign sel_ld  = ld_req & (~wb_req | rr_ld_q);
  assign w_addr  = sel_ld ? ld_addr : wb_addr;
  assign w_data  = sel_ld ? ld_data : wb_data;
  assign w_len   = sel_ld ? ld_len  : wb_len;
  assign starved = wr_pend & (cnt_q == CNT_W'(STARVE_LIMIT));

`ifdef REGFILE_PAIR_CHECK_EN
  assign pair_bad = w_len & (w_addr == AW'(7));
`else
  assign pair_bad = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_ld_d       = rr_ld_q;
    lo_addr_d     = lo_addr_q;
    lo_data_d     = lo_data_q;
    rd_gnt_d      = 1'b0;
    wb_gnt_d      = 1'b0;
    ld_gnt_d      = 1'b0;
    busy_d        = 1'b0;
    err_d         = err;
    rf_r_w_d      = 1'b1;
    rf_rs1_addr_d = rf_rs1_addr;
    rf_rs2_addr_d = rf_rs2_addr;
    rf_rd_addr_d  = rf_rd_addr;
    rf_rd_data_d  = rf_rd_data;
    rd_vld_d      = rd_gnt;
    rd_rs1_d      = rd_gnt ? rf_rs1_data : rd_rs1_q;
    rd_rs2_d      = rd_gnt ? rf_rs2_data : rd_rs2_q;

    case (state_q)
      IDLE: begin
        if (wr_pend && (starved || !rd_req)) begin
          cnt_d    = '0;
          rr_ld_d  = ~sel_ld;
          wb_gnt_d = ~sel_ld;
          ld_gnt_d = sel_ld;
          err_d    = err | pair_bad;
          if (!pair_bad) begin
            rf_r_w_d     = 1'b0;
            rf_rd_addr_d = w_addr;
            if (w_len) begin
              rf_rd_data_d = w_data[15:8];
              lo_addr_d    = AW'(w_addr + AW'(1));
              lo_data_d    = w_data[7:0];
              busy_d       = 1'b1;
              state_d      = WR_LO;
            end else begin
              rf_rd_data_d = w_data[7:0];
            end
          end
        end else if (rd_req) begin
          rd_gnt_d      = 1'b1;
          rf_rs1_addr_d = rd_rs1_addr;
          rf_rs2_addr_d = rd_rs2_addr;
          if (!wr_pend)
            cnt_d = '0;
          else if (cnt_q != CNT_W'(STARVE_LIMIT))
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end else begin
          cnt_d = '0;
        end
      end
      WR_LO: begin
        // Second byte of a pair; requesters keep waiting.
        rf_r_w_d     = 1'b0;
        rf_rd_addr_d = lo_addr_q;
        rf_rd_data_d = lo_data_q;
        busy_d       = 1'b1;
        state_d      = IDLE;
        if (!wr_pend) cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_ld_q     <= 1'b0;
      lo_addr_q   <= '0;
      lo_data_q   <= '0;
      rd_gnt      <= 1'b0;
      wb_gnt      <= 1'b0;
      ld_gnt      <= 1'b0;
      rd_vld      <= 1'b0;
      rd_rs1_q    <= '0;
      rd_rs2_q    <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
      rf_r_w      <= 1'b1;
      rf_rs1_addr <= '0;
      rf_rs2_addr <= '0;
      rf_rd_addr  <= '0;
      rf_rd_data  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ld_q     <= rr_ld_d;
      lo_addr_q   <= lo_addr_d;
      lo_data_q   <= lo_data_d;
      rd_gnt      <= rd_gnt_d;
      wb_gnt      <= wb_gnt_d;
      ld_gnt      <= ld_gnt_d;
      rd_vld      <= rd_vld_d;
      rd_rs1_q    <= rd_rs1_d;
      rd_rs2_q    <= rd_rs2_d;
      busy        <= busy_d;
      err         <= err_d;
      rf_r_w      <= rf_r_w_d;
      rf_rs1_addr <= rf_rs1_addr_d;
      rf_rs2_addr <= rf_rs2_addr_d;
      rf_rd_addr  <= rf_rd_addr_d;
      rf_rd_data  <= rf_rd_data_d;
    end
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Sequences all accesses to the 8x8-bit register file, which has one shared read/write control.
- Arbitrates three requesters: decode reads (rs1/rs2 pair), execute writeback, and load-unit writeback.
- Splits 16-bit writes into two 8-bit write cycles: high byte to rd, low byte to rd+1.
- Sits between the decode/execute/load stages and the register file.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a pending write may lose to reads before it is forced ahead.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- rd_req  in  1  decode read request
- rd_rs1_addr  in  3  read address 1
- rd_rs2_addr  in  3  read address 2
- rd_gnt  out  1  one-cycle pulse: read accepted this cycle
- rd_vld  out  1  one-cycle pulse: rd_rs1_q and rd_rs2_q valid
- rd_rs1_q  out  8  registered read data 1
- rd_rs2_q  out  8  registered read data 2
- wb_req  in  1  execute write request, held until wb_gnt
- wb_addr  in  3  execute destination
- wb_data  in  16  execute data; low byte used when wb_len=0
- wb_len  in  1  0 = 8-bit write, 1 = 16-bit write
- wb_gnt  out  1  pulse when the request is accepted
- ld_req, ld_addr, ld_data, ld_len, ld_gnt: same widths and semantics as the wb_* group, for the load unit
- rf_rs1_addr  out  3  to register file
- rf_rs2_addr  out  3  to register file
- rf_rd_addr  out  3  to register file
- rf_rd_data  out  8  to register file
- rf_r_w  out  1  1 = read, 0 = write
- rf_rs1_data  in  8  from register file
- rf_rs2_data  in  8  from register file
- busy  out  1  high while a 16-bit write is in progress
- err  out  1  sticky illegal-pair-write flag (see Optional Feature)

Behaviour:
- Reset (reset=0 at a clk edge), outputs:
  - rf_r_w=1; all rf_* address/data outputs = 0
  - all gnt pulses, rd_vld, busy, err = 0
  - rd_rs1_q = rd_rs2_q = 0
  - state=IDLE; starvation counter=0; round-robin pointer points to wb
- Reset mid-16-bit-write abandons the second byte; the request is not retried.
- States:
  - IDLE: arbitrate.
  - WR_LO: second half of a 16-bit write.
- IDLE arbitration, evaluated each cycle:
  - If a write is pending and the starvation counter equals STARVE_LIMIT, the write wins.
  - Otherwise rd_req wins over writes.
  - Between wb and ld, the round-robin pointer decides; the pointer flips to the other requester after each write grant.
- Read grant:
  - rf_r_w=1; rf_rs1_addr/rf_rs2_addr driven from rd_* the same cycle; rd_gnt=1.
  - Next cycle: rd_rs1_q/rd_rs2_q capture rf_rs*_data and rd_vld=1. Latency is 1 cycle.
  - Back-to-back reads are allowed every cycle.
- Write grant:
  - rf_r_w=0; gnt pulse to the winner.
  - 8-bit write: rf_rd_addr=addr, rf_rd_data=data[7:0]. Stay in IDLE.
  - 16-bit write: rf_rd_addr=addr, rf_rd_data=data[15:8]; latch addr+1 and data[7:0]; go to WR_LO; busy=1.
- WR_LO:
  - rf_r_w=0; rf_rd_addr=latched addr; rf_rd_data=latched low byte; busy stays 1 this cycle.
  - Return to IDLE. No grants are issued in WR_LO; requests stay pending.
- Starvation counter:
  - Increments on each cycle a write is pending and a read wins, saturating at STARVE_LIMIT.
  - Clears on any write grant, or when no write is pending.
- Requesters hold req, addr and data stable until gnt. The controller samples them only in the grant cycle.
- Simultaneous wb_req and ld_req to the same address: both are serviced in round-robin order. Last granted data persists.
- Idle cycles (no grant): rf_r_w=1 and rf_* addresses hold their previous values.

Optional Feature:
- Macro REGFILE_PAIR_CHECK_EN.
- Defined: a 16-bit write with addr=7 is granted (gnt pulses) but performs no register write. rf_r_w stays 1, the state stays IDLE, and err is set sticky until reset.
- Undefined: the low byte wraps to address 0 (addr+1 modulo 8), and err is tied to 0.

Test Plan:
- Reset held low 2 cycles with all req high -> no gnt; rf_r_w=1; busy=0; after release, first grant goes to rd_req.
- rd_req with rs1=2, rs2=5, regfile holding 0x11/0x55 -> rd_gnt in cycle N; rd_vld, rd_rs1_q=0x11 and rd_rs2_q=0x55 in cycle N+1.
- wb 16-bit write addr=3, data=0xABCD -> cycle N: rf_r_w=0, addr 3, data 0xAB; cycle N+1: addr 4, data 0xCD, busy=1; cycle N+2: IDLE.
- wb_req and ld_req asserted together, each 8-bit, continuously -> grants alternate wb, ld, wb, ld.
- rd_req held high with wb_req pending, STARVE_LIMIT=4 -> 4 read grants, then wb_gnt on the 5th cycle.
- 16-bit write at addr=7 -> with REGFILE_PAIR_CHECK_EN: no write, err=1; without it: writes to 7 then 0, err=0.
